// File: rtl/dino_pkg.sv
// Shared types and default geometry for the runner game (jump controller, renderer, collision checker).
package dino_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      RISE = 3'd2,
      HANG = 3'd3,
      FALL = 3'd4,
      OVER = 3'd5
   } state_t;

   localparam int DINO_HEIGHT_W   = 6;
   localparam int DINO_MAX_HEIGHT = 40;
   localparam int DINO_V0         = 7;
   localparam int DINO_GRAVITY    = 1;
   localparam int DINO_HANG_TICKS = 2;
   localparam int DINO_CNT_W      = 16;

endpackage

// File: rtl/dino_edge_detect.sv
// Jump button edge detector with a pending-jump latch that holds a press until the next frame tick.
module dino_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   input  logic i_arm,
   input  logic i_clr,
   input  logic i_consume,
   output logic o_press,
   output logic o_pending
);

   logic r_btn_q;
   logic r_pending;

   assign o_press   = i_btn & ~r_btn_q;
   assign o_pending = r_pending;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_btn_q   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_btn_q <= i_btn;
         // a press landing on the consuming tick is dropped rather than queued
         if (i_clr || i_consume) r_pending <= 1'b0;
         else if (o_press && i_arm) r_pending <= 1'b1;
      end
   end

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dinosaur jump physics and game-state FSM, advanced once per frame tick.
// Optional DINO_DOUBLE_JUMP_EN allows one extra airborne press per jump.
module dino_jump_ctrl
   import dino_pkg::*;
#(
   parameter int HEIGHT_W   = DINO_HEIGHT_W,
   parameter int MAX_HEIGHT = DINO_MAX_HEIGHT,
   parameter int V0         = DINO_V0,
   parameter int GRAVITY    = DINO_GRAVITY,
   parameter int HANG_TICKS = DINO_HANG_TICKS,
   parameter int CNT_W      = DINO_CNT_W
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                tick,
   input  logic                button_jump,
   input  logic                collision,
   output logic [HEIGHT_W-1:0] dinosaur_height,
   output logic                game_status,
   output logic                game_over,
   output logic                airborne,
   output logic [CNT_W-1:0]    jump_count
);

   localparam int VEL_W = $clog2(V0 + 1);
   localparam int VS_W  = VEL_W + 1;
   localparam int SUM_W = HEIGHT_W + 1;
   localparam int HC_W  = (HANG_TICKS < 1) ? 1 : $clog2(HANG_TICKS + 1);

   if (MAX_HEIGHT >= (1 << HEIGHT_W)) begin : g_bad_max
      $error("MAX_HEIGHT must be below 2**HEIGHT_W");
   end
   if (GRAVITY < 1 || GRAVITY > V0) begin : g_bad_grav
      $error("GRAVITY must satisfy 1 <= GRAVITY <= V0");
   end

   state_t              r_state, w_state_nxt;
   logic [HEIGHT_W-1:0] r_height, w_height_nxt;
   logic [VEL_W-1:0]    r_vel, w_vel_nxt;
   logic [HC_W-1:0]     r_hang, w_hang_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                r_status, r_over, r_air;

   logic                w_press, w_pending, w_arm, w_clr, w_consume;
   logic                w_in_air, w_dbl, w_air_arm;
   logic [VEL_W-1:0]    w_rv, w_rise_v, w_fall_v;
   logic [SUM_W-1:0]    w_sum;
   logic [HEIGHT_W-1:0] w_rise_h, w_fall_h;
   logic                w_rise_hang;
   logic [VS_W-1:0]     w_vsum;

   dino_edge_detect u_edge (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_btn     (button_jump),
      .i_arm     (w_arm),
      .i_clr     (w_clr),
      .i_consume (w_consume),
      .o_press   (w_press),
      .o_pending (w_pending)
   );

   assign w_in_air = (r_state == RISE) || (r_state == HANG) || (r_state == FALL);

`ifdef DINO_DOUBLE_JUMP_EN
   logic r_used;
   assign w_dbl     = w_pending & w_in_air;
   assign w_air_arm = ~r_used;

   always_ff @(posedge CLK) begin
      if (RST) r_used <= 1'b0;
      else if (w_state_nxt == RUN || w_state_nxt == OVER) r_used <= 1'b0;
      else if (w_consume && w_dbl) r_used <= 1'b1;
   end
`else
   assign w_dbl     = 1'b0;
   assign w_air_arm = 1'b0;
`endif

   // rise step; a double jump reuses it with the velocity reloaded to V0
   assign w_rv        = w_dbl ? VEL_W'(V0) : r_vel;
   assign w_sum       = SUM_W'(r_height) + SUM_W'(w_rv);
   assign w_rise_h    = (w_sum >= SUM_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT) : w_sum[HEIGHT_W-1:0];
   assign w_rise_hang = (w_rv <= VEL_W'(GRAVITY)) || (w_sum >= SUM_W'(MAX_HEIGHT));
   assign w_rise_v    = w_rv - VEL_W'(GRAVITY);

   assign w_fall_h    = (SUM_W'(r_height) > SUM_W'(r_vel)) ? (r_height - HEIGHT_W'(r_vel)) : '0;
   assign w_vsum      = VS_W'(r_vel) + VS_W'(GRAVITY);
   assign w_fall_v    = (w_vsum > VS_W'(V0)) ? VEL_W'(V0) : w_vsum[VEL_W-1:0];

   assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_height_nxt = r_height;
      w_vel_nxt    = r_vel;
      w_hang_nxt   = r_hang;
      w_cnt_nxt    = r_cnt;
      w_arm        = 1'b0;
      w_clr        = 1'b0;
      w_consume    = 1'b0;
      case (r_state)
         IDLE: begin
            w_clr = 1'b1;
            if (w_press) w_state_nxt = RUN;
         end
         RUN: begin
            w_arm = 1'b1;
            if (collision) begin
               w_state_nxt = OVER;
               w_clr       = 1'b1;
            end else if (tick && w_pending) begin
               w_consume   = 1'b1;
               w_vel_nxt   = VEL_W'(V0);
               w_cnt_nxt   = w_cnt_inc;
               w_state_nxt = RISE;
            end
         end
         RISE, HANG, FALL: begin
            w_arm = w_air_arm;
            if (collision) begin
               w_state_nxt = OVER;
               w_clr       = 1'b1;
            end else if (tick) begin
               if (w_dbl) begin
                  w_consume    = 1'b1;
                  w_cnt_nxt    = w_cnt_inc;
                  w_height_nxt = w_rise_h;
                  w_vel_nxt    = w_rise_v;
                  w_state_nxt  = RISE;
               end else if (r_state == RISE) begin
                  w_height_nxt = w_rise_h;
                  w_vel_nxt    = w_rise_v;
                  if (w_rise_hang) begin
                     w_state_nxt = HANG;
                     w_hang_nxt  = HC_W'(HANG_TICKS);
                  end
               end else if (r_state == HANG) begin
                  if (r_hang <= HC_W'(1)) begin
                     w_state_nxt = FALL;
                     w_hang_nxt  = '0;
                     w_vel_nxt   = VEL_W'(GRAVITY);
                  end else begin
                     w_hang_nxt = r_hang - HC_W'(1);
                  end
               end else begin
                  w_height_nxt = w_fall_h;
                  if (w_fall_h == '0) begin
                     w_state_nxt = RUN;
                     w_vel_nxt   = '0;
                  end else begin
                     w_vel_nxt = w_fall_v;
                  end
               end
            end
         end
         OVER: begin
            w_clr = 1'b1;
            if (w_press) begin
               w_state_nxt  = RUN;
               w_height_nxt = '0;
               w_vel_nxt    = '0;
               w_hang_nxt   = '0;
               w_cnt_nxt    = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_height <= '0;
         r_vel    <= '0;
         r_hang   <= '0;
         r_cnt    <= '0;
         r_status <= 1'b0;
         r_over   <= 1'b0;
         r_air    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_height <= w_height_nxt;
         r_vel    <= w_vel_nxt;
         r_hang   <= w_hang_nxt;
         r_cnt    <= w_cnt_nxt;
         r_status <= w_state_nxt inside {RUN, RISE, HANG, FALL};
         r_over   <= (w_state_nxt == OVER);
         r_air    <= w_state_nxt inside {RISE, HANG, FALL};
      end
   end

   assign dinosaur_height = r_height;
   assign game_status     = r_status;
   assign game_over       = r_over;
   assign airborne        = r_air;
   assign jump_count      = r_cnt;

endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
- Parametrised dinosaur jump and game-state controller for the runner game.
- Turns the debounced jump button and the collision flag into a game state (IDLE/RUN/OVER) and a per-frame dinosaur height with velocity-based rise, hang and fall.
- Sits between the input-conditioning logic and the renderer/collision checker.
- Updates once per frame tick.

Parameters:
- HEIGHT_W, 6, width of dinosaur_height.
- MAX_HEIGHT, 40, ceiling for height; must be less than 2^HEIGHT_W (elaboration error otherwise).
- V0, 7, initial upward velocity in height units per tick.
- GRAVITY, 1, velocity change per tick; must satisfy 1 ≤ GRAVITY ≤ V0.
- HANG_TICKS, 2, number of ticks held at the apex.
- CNT_W, 16, width of jump_count.

Ports:
- CLK, in, 1, system clock; all logic is on the rising edge.
- RST, in, 1, synchronous active-high reset.
- tick, in, 1, one-cycle frame strobe; the physics advances only on cycles where tick=1.
- button_jump, in, 1, debounced level; its rising edge is the press event.
- collision, in, 1, high when the collision checker detects an obstacle hit.
- dinosaur_height, out, HEIGHT_W, current height above ground.
- game_status, out, 1, 1 while the game is running (states RUN/RISE/HANG/FALL).
- game_over, out, 1, 1 in state OVER.
- airborne, out, 1, 1 in states RISE/HANG/FALL.
- jump_count, out, CNT_W, number of accepted jumps since game start; saturates at all-ones.

Behaviour:
- Reset (RST=1 on a clock edge):
  - state=IDLE.
  - dinosaur_height=0, vel=0, hang_cnt=0, jump_count=0.
  - All flag outputs are 0; the edge-detect register is cleared.
  - Reset has priority over every other event, including in mid-air.
- Press event:
  - press = button_jump & ~button_q, where button_q is registered every clock.
  - Presses are sampled on every clock, not only on tick cycles.
  - A press is latched into pending_jump and consumed on the next tick.
  - pending_jump is cleared on entry to IDLE or OVER.
- IDLE: press -> RUN, taking effect the next cycle. That press does not start a jump.
- RUN (height=0): on a tick with pending_jump:
  - vel=V0, state=RISE.
  - jump_count increments, saturating.
- RISE, on each tick:
  - height=min(height+vel, MAX_HEIGHT); vel=vel-GRAVITY.
  - If vel ≤ GRAVITY or height+vel ≥ MAX_HEIGHT: go to HANG with hang_cnt=HANG_TICKS.
- HANG, on each tick:
  - hang_cnt decrements.
  - When hang_cnt reaches 0: go to FALL with vel=GRAVITY.
  - HANG_TICKS=0 means HANG is passed through in a single tick.
- FALL, on each tick:
  - height=max(height-vel, 0), computed with no underflow; vel=min(vel+GRAVITY, V0).
  - height reaching 0 -> RUN; vel=0.
- Collision:
  - collision=1 in RUN/RISE/HANG/FALL -> OVER on the next edge, independent of tick.
  - height is frozen at its current value.
  - On the same edge, collision beats a press or tick.
- OVER:
  - collision is ignored.
  - press -> RUN with height=0, vel=0, jump_count=0.
- Presses in RISE/HANG/FALL are discarded unless the optional feature below is compiled in.
- Width rules:
  - Internal sums are computed at HEIGHT_W+1 bits so saturation is exact.
  - vel is $clog2(V0+1) bits wide.
- Outputs are registered and valid the cycle after the state change. No combinational path exists from input to output.

Optional Feature:
- Macro: DINO_DOUBLE_JUMP_EN.
- Defined:
  - One extra press is allowed per airborne period, in RISE/HANG/FALL.
  - On the next tick it reloads vel=V0, forces RISE and increments jump_count.
  - A used_double flag blocks further presses; it clears on landing in RUN, on RST and on entering OVER.
- Undefined:
  - No used_double register exists.
  - Airborne presses are dropped.

Decomposition:
- Shared package dino_pkg:
  - State typedef (IDLE, RUN, RISE, HANG, FALL, OVER), 3-bit encoding.
  - Default constants for the parameters, so the renderer and the collision checker use the same MAX_HEIGHT and HEIGHT_W.
- One sub-module: dino_edge_detect. It holds the registered button sample, the press pulse and the pending latch, with synchronous RST.

Test Plan:
- Reset then press -> game_status=1 the next cycle, height stays 0, jump_count=0.
- Default parameters, one press then ticks:
  - Rise heights 7,13,18,22,25,27,28.
  - Two hang ticks at 28.
  - Fall heights 27,25,22,18,13,7,0.
  - 16 ticks in total; airborne deasserts with the final 0; jump_count=1.
- collision asserted at height 22 during rise on the same edge as a press -> game_over=1, height frozen at 22, press ignored. A later press -> RUN, height 0, jump_count 0.
- MAX_HEIGHT=20 -> height clamps at 20 and HANG is entered on the clamp tick. No wrap is allowed at HEIGHT_W=5, MAX_HEIGHT=31, V0=15.
- RST asserted at height 18 mid-fall -> next cycle IDLE, height 0, all flags 0.
- With DINO_DOUBLE_JUMP_EN:
  - A press at height 25 during rise -> vel reloaded to 7 and next height 32 (MAX_HEIGHT=40); jump_count=2; a third press is ignored.
  - Without the macro, the same stimulus follows the default trajectory.
